regfile_wb: RTL and testbench
=============================

# regfile_wb

Architectural register-file write side, the producer end of the issue-stage operand path. Holds the 31 writable GPRs (r0 hard-wired zero) and HI/LO, and commits up to two retire lanes per cycle with in-order lane priority. Serves four raw read ports and the HI/LO read pair that the forwarding network overlays with in-flight results. Also keeps per-register in-flight writer counts, set at issue and cleared at retire, so the issue stage knows which operands are still owed by the pipeline.

## Interface
Parameters:
- `CNT_W`, 3: width of each in-flight writer counter; must cover the maximum number of writers in flight between issue and retire.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `reg_addrR`  in  4×5 (`creg_addr_t [3:0]`)  read addresses.
- `reg_dataR`  out  4×32 (`word_t [3:0]`)  read data; combinational from current state.
- `hiloreadR`  in  2  HI/LO read requests; informational only, HI/LO are always driven.
- `hiR`, `loR`  out  32 each  current HI and LO.
- `ret_wen`  in  2  per-lane GPR write enable; lane 0 older.
- `ret_waddr`  in  2×5  per-lane destination.
- `ret_wdata`  in  2×32  per-lane GPR data.
- `ret_hiwen`, `ret_lowen`  in  2 each  per-lane HI/LO write enables.
- `ret_hidata`, `ret_lodata`  in  2×32 each  per-lane HI/LO data.
- `iss_wen`  in  2  per-lane "issued instruction will write GPR".
- `iss_waddr`  in  2×5  issued destinations.
- `iss_hilo`  in  2  per-lane "issued instruction will write HI and/or LO".
- `flush`  in  1  pipeline flush; drops all in-flight writers.
- `busy`  out  32  bit i = GPR i has an in-flight writer; bit 0 is always 0.
- `hilo_busy`  out  1  HI/LO has an in-flight writer.

## Operation
- Reads are asynchronous and return the stored value only, with no write-through. A same-cycle retire is visible through the forwarding network, not through this block. Address 0 reads 0.
- GPR commit: for each lane with `ret_wen` set and `ret_waddr` not 0, write `ret_wdata`. If both lanes target the same register, lane 1 wins. Writes to r0 are discarded.
- HI/LO commit: HI and LO are handled independently, with the same lane-1-wins rule.
- In-flight counters: one `CNT_W`-bit counter per GPR 1..31 and one for HI/LO.
  - The next value is cnt + (issue hits this cycle, 0..2) − (retire hits this cycle, 0..2).
  - A hit to r0 is ignored.
  - Retire hits for HI/LO count lanes with `ret_hiwen` or `ret_lowen` set.
- `busy[i]` is `cnt[i] != 0`, decoded from registered state, so there is no same-cycle issue visibility. `hilo_busy` is the same for the HI/LO counter.
- `flush` synchronously clears all counters; the retire writes in that same cycle still commit. Retire-side instructions are never flushed, and the issuing lanes that cycle are dropped.
- Counter boundary conditions are protocol violations: flag with assertions, no saturation logic.
  - Underflow: retire with count 0.
  - Overflow: increment past 2^`CNT_W`−1.

## Timing
- Reset (asynchronous, `resetn` low): all GPRs, HI, LO and counters go to 0. `reg_dataR` reflects zeros immediately, `hiR`/`loR` = 0, and `busy`/`hilo_busy` = 0.
- Read latency: 0 cycles, combinational from state.
- Write latency: data retired in cycle N is readable from cycle N+1.
- Counter latency: a counter updated in cycle N is reflected on `busy` in cycle N+1.
- Simultaneous issue and retire on one register in the same cycle: net change is applied. For example, +1 −1 leaves the count and `busy` unchanged.
- Reset asserted mid-operation overrides all writes and flush.

## Structure
- Shared package (`mips.svh`): `creg_addr_t`, `word_t`, and a new `retire_wb_t` bundle (wen, waddr, wdata, hiwen, lowen, hidata, lodata) for future port grouping. Define `CNT_W` there as a constant.
- One sub-module, `wr_counter`: a single in-flight counter with two increment bits, two decrement bits, flush and the asynchronous active-low reset. It is instantiated 31 times plus once for HI/LO.
- The register array is a flip-flop array, not inferred RAM, because it needs four asynchronous read ports.

## Test plan
- Reset then read: hold `resetn` low with arbitrary inputs → all `reg_dataR`, `hiR`/`loR` = 0 and `busy` = 0. Release, read r5 → 0.
- Dual-lane same-destination retire: lane 0 writes r3 = 0x1111_1111 and lane 1 writes r3 = 0x2222_2222 in cycle N → in cycle N the read of r3 is 0; in cycle N+1 it is 0x2222_2222.
- r0 protection: retire r0 = 0xDEAD_BEEF and issue r0 → r0 reads 0, `busy[0]` = 0 throughout.
- HI/LO split: lane 0 `hiwen` with HI = 0xA, lane 1 `lowen` with LO = 0xB → next cycle `hiR` = 0xA, `loR` = 0xB. `hilo_busy` follows the issue/retire sequence with 2 issues then 2 retires: 0,1,1,1,0 timing per counter latency.
- Counter sequence on r7: issue both lanes to r7 (count 2), then in one cycle issue 1 and retire 1 (count 2, `busy[7]` still 1), then retire 2 → `busy[7]` = 0 in the following cycle.
- Flush: after 3 outstanding writers on r9, assert `flush` with a same-cycle retire of r9 = 0x55 → `busy` = 0 next cycle and r9 reads 0x55.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write side.
//   creg_addr_t  - architectural GPR address (r0..r31)
//   word_t       - 32-bit data word
//   retire_wb_t  - one retire lane's writeback bundle, for grouping ports later
//   CNT_W        - default width of each in-flight writer counter
package regfile_wb_pkg;

  localparam int CNT_W = 3;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic       wen;
    creg_addr_t waddr;
    word_t      wdata;
    logic       hiwen;
    logic       lowen;
    word_t      hidata;
    word_t      lodata;
  } retire_wb_t;

endpackage

// File: rtl/regfile_wb_wr_counter.sv
// In-flight writer counter for one architectural destination.
//   clk, resetn - clock and asynchronous active-low reset
//   inc[1:0]    - per-lane issue hits this cycle
//   dec[1:0]    - per-lane retire hits this cycle
//   flush       - drops every in-flight writer (counter goes to 0)
//   busy        - registered count is non-zero
// Underflow and overflow are protocol violations; they are asserted on,
// not saturated.
module wr_counter #(
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] inc,
  input  logic [1:0] dec,
  input  logic       flush,
  output logic       busy
);

  // Two spare bits so that +2 on a full counter and -2 on an empty one
  // both stay representable for the checks below.
  localparam int EXT_W = CNT_W + 2;
  localparam logic [EXT_W-1:0] CNT_MAX = EXT_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [EXT_W-1:0] up;
  logic [EXT_W-1:0] down;
  logic [EXT_W-1:0] base;
  logic [EXT_W-1:0] sum;
  logic             underflow;
  logic             overflow;

  assign up        = EXT_W'(inc[0]) + EXT_W'(inc[1]);
  assign down      = EXT_W'(dec[0]) + EXT_W'(dec[1]);
  assign base      = EXT_W'(cnt_q) + up;
  assign underflow = base < down;
  assign sum       = base - down;
  assign overflow  = !underflow && (sum > CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= sum[CNT_W-1:0];
    end
  end

  assign busy = (cnt_q != '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> !underflow);
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> !overflow);

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file, write side.
//   clk, resetn                 - clock, asynchronous active-low reset
//   reg_addrR / reg_dataR       - four raw combinational read ports (r0 reads 0)
//   hiloreadR                   - HI/LO read requests (HI/LO always driven)
//   hiR, loR                    - current HI and LO
//   ret_*                       - two retire lanes, lane 0 older, lane 1 wins
//                                 on a shared destination
//   iss_wen, iss_waddr, iss_hilo - issue-side in-flight writer registration
//   flush                       - drops all in-flight writers
//   busy, hilo_busy             - registered "writer still in flight" flags
// Reads return stored state only; same-cycle retire data is provided by the
// forwarding network outside this block.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int CNT_W = regfile_wb_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  creg_addr_t [3:0] reg_addrR,
  output word_t      [3:0] reg_dataR,
  input  logic       [1:0] hiloreadR,
  output word_t            hiR,
  output word_t            loR,
  input  logic       [1:0] ret_wen,
  input  creg_addr_t [1:0] ret_waddr,
  input  word_t      [1:0] ret_wdata,
  input  logic       [1:0] ret_hiwen,
  input  logic       [1:0] ret_lowen,
  input  word_t      [1:0] ret_hidata,
  input  word_t      [1:0] ret_lodata,
  input  logic       [1:0] iss_wen,
  input  creg_addr_t [1:0] iss_waddr,
  input  logic       [1:0] iss_hilo,
  input  logic             flush,
  output logic      [31:0] busy,
  output logic             hilo_busy
);

  // Flop array rather than RAM: four asynchronous read ports.
  word_t gpr_q [1:31];
  word_t hi_q;
  word_t lo_q;

  // Lane 1 is applied after lane 0, so it wins on a shared destination.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (ret_wen[l] && (ret_waddr[l] != '0)) begin
          gpr_q[ret_waddr[l]] <= ret_wdata[l];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (ret_hiwen[l]) begin
          hi_q <= ret_hidata[l];
        end
        if (ret_lowen[l]) begin
          lo_q <= ret_lodata[l];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      reg_dataR[p] = '0;
      if (reg_addrR[p] != '0) begin
        reg_dataR[p] = gpr_q[reg_addrR[p]];
      end
    end
  end

  assign hiR = hi_q;
  assign loR = lo_q;

  // r0 never has a writer in flight.
  assign busy[0] = 1'b0;

  for (genvar g = 1; g < 32; g++) begin : g_gpr_cnt
    logic [1:0] inc;
    logic [1:0] dec;

    assign inc[0] = iss_wen[0] && (iss_waddr[0] == 5'(g));
    assign inc[1] = iss_wen[1] && (iss_waddr[1] == 5'(g));
    assign dec[0] = ret_wen[0] && (ret_waddr[0] == 5'(g));
    assign dec[1] = ret_wen[1] && (ret_waddr[1] == 5'(g));

    wr_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .resetn(resetn),
      .inc   (inc),
      .dec   (dec),
      .flush (flush),
      .busy  (busy[g])
    );
  end

  // One HI/LO writer may update either or both halves; it retires once.
  wr_counter #(
    .CNT_W(CNT_W)
  ) u_hilo_cnt (
    .clk   (clk),
    .resetn(resetn),
    .inc   (iss_hilo),
    .dec   (ret_hiwen | ret_lowen),
    .flush (flush),
    .busy  (hilo_busy)
  );

  logic [1:0] unused_hiloread;
  assign unused_hiloread = hiloreadR;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  logic             clk;
  logic             resetn;
  creg_addr_t [3:0] reg_addrR;
  word_t      [3:0] reg_dataR;
  logic       [1:0] hiloreadR;
  word_t            hiR;
  word_t            loR;
  logic       [1:0] ret_wen;
  creg_addr_t [1:0] ret_waddr;
  word_t      [1:0] ret_wdata;
  logic       [1:0] ret_hiwen;
  logic       [1:0] ret_lowen;
  word_t      [1:0] ret_hidata;
  word_t      [1:0] ret_lodata;
  logic       [1:0] iss_wen;
  creg_addr_t [1:0] iss_waddr;
  logic       [1:0] iss_hilo;
  logic             flush;
  logic      [31:0] busy;
  logic             hilo_busy;

  int errors = 0;
  int checks = 0;

  regfile_wb #(.CNT_W(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .reg_addrR (reg_addrR),
    .reg_dataR (reg_dataR),
    .hiloreadR (hiloreadR),
    .hiR       (hiR),
    .loR       (loR),
    .ret_wen   (ret_wen),
    .ret_waddr (ret_waddr),
    .ret_wdata (ret_wdata),
    .ret_hiwen (ret_hiwen),
    .ret_lowen (ret_lowen),
    .ret_hidata(ret_hidata),
    .ret_lodata(ret_lodata),
    .iss_wen   (iss_wen),
    .iss_waddr (iss_waddr),
    .iss_hilo  (iss_hilo),
    .flush     (flush),
    .busy      (busy),
    .hilo_busy (hilo_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: retire lanes, issue lanes, flush, two read addrs, then
  // expected state after the clock edge.
  typedef struct {
    logic [1:0]  ret_wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  hiwen, lowen;
    logic [31:0] hd0, hd1, ld0, ld1;
    logic [1:0]  iss_wen;
    logic [4:0]  ia0, ia1;
    logic [1:0]  iss_hilo;
    logic        flush;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [31:0] ebusy;
    logic        ehb;
    logic [31:0] ehi, elo;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    ret_wen = '0; ret_waddr = '0; ret_wdata = '0;
    ret_hiwen = '0; ret_lowen = '0; ret_hidata = '0; ret_lodata = '0;
    iss_wen = '0; iss_waddr = '0; iss_hilo = '0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ret_wen = v.ret_wen;
    ret_waddr[0] = v.wa0; ret_waddr[1] = v.wa1;
    ret_wdata[0] = v.wd0; ret_wdata[1] = v.wd1;
    ret_hiwen = v.hiwen; ret_lowen = v.lowen;
    ret_hidata[0] = v.hd0; ret_hidata[1] = v.hd1;
    ret_lodata[0] = v.ld0; ret_lodata[1] = v.ld1;
    iss_wen = v.iss_wen;
    iss_waddr[0] = v.ia0; iss_waddr[1] = v.ia1;
    iss_hilo = v.iss_hilo;
    flush = v.flush;
    reg_addrR[0] = v.ra0; reg_addrR[1] = v.ra1;
    reg_addrR[2] = v.ra1; reg_addrR[3] = v.ra0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ret   wa0    wa1    wd0           wd1           hiw    low    hd0          hd1          ld0          ld1          iss    ia0    ia1    hilo   fl    ra0    ra1    e0            e1            busy          hb    hi           lo
    tv[0]  = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b11, 5'd10, 5'd11, 2'b00, 1'b0, 5'd10, 5'd11, '0,           '0,           32'h0000_0C00, 1'b0, '0,          '0};
    tv[1]  = '{2'b11, 5'd10, 5'd11, 32'hAAAA0001, 32'hBBBB0002, 2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b01, 5'd12, '0,    2'b00, 1'b0, 5'd10, 5'd11, 32'hAAAA0001, 32'hBBBB0002, 32'h0000_1000, 1'b0, '0,          '0};
    tv[2]  = '{2'b10, 5'd12, 5'd12, 32'hDEAD0000, 32'h12345678, 2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b01, 5'd12, '0,    2'b00, 1'b0, 5'd12, 5'd10, 32'h12345678, 32'hAAAA0001, 32'h0000_1000, 1'b0, '0,          '0};
    tv[3]  = '{2'b11, 5'd12, 5'd0,  32'h000000FF, 32'hDEADBEEF, 2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b11, 5'd0,  5'd0,  2'b00, 1'b0, 5'd12, 5'd0,  32'h000000FF, '0,           '0,            1'b0, '0,          '0};
    tv[4]  = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b01, 1'b0, 5'd3,  5'd11, 32'h22222222, 32'hBBBB0002, '0,            1'b1, '0,          '0};
    tv[5]  = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b10, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b1, '0,          '0};
    tv[6]  = '{2'b00, '0,    '0,    '0,           '0,           2'b01, 2'b00, 32'h0000000A, 32'h0000FFFF, '0,        '0,          2'b00, '0,    '0,    2'b00, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b1, 32'h0000000A, '0};
    tv[7]  = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b10, '0,          '0,          32'h0000EEEE, 32'h0000000B, 2'b00, '0, '0,    2'b00, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b0, 32'h0000000A, 32'h0000000B};
    tv[8]  = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b11, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b1, 32'h0000000A, 32'h0000000B};
    tv[9]  = '{2'b00, '0,    '0,    '0,           '0,           2'b11, 2'b10, 32'h00000100, 32'h00000200, '0,        32'h00000300, 2'b00, '0, '0,    2'b00, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b0, 32'h00000200, 32'h00000300};
    tv[10] = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b11, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b1, 32'h00000200, 32'h00000300};
    tv[11] = '{2'b00, '0,    '0,    '0,           '0,           2'b01, 2'b10, 32'h0000000A, '0,        '0,          32'h0000000B, 2'b00, '0,    '0,    2'b00, 1'b0, 5'd3,  5'd12, 32'h22222222, 32'h000000FF, '0,            1'b0, 32'h0000000A, 32'h0000000B};
    tv[12] = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b11, 5'd7,  5'd7,  2'b00, 1'b0, 5'd7,  5'd3,  '0,           32'h22222222, 32'h0000_0080, 1'b0, 32'h0000000A, 32'h0000000B};
    tv[13] = '{2'b01, 5'd7,  '0,    32'h00000007, '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b01, 5'd7,  '0,    2'b00, 1'b0, 5'd7,  5'd3,  32'h00000007, 32'h22222222, 32'h0000_0080, 1'b0, 32'h0000000A, 32'h0000000B};
    tv[14] = '{2'b11, 5'd7,  5'd7,  32'h00000070, 32'h00000071, 2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b00, 1'b0, 5'd7,  5'd3,  32'h00000071, 32'h22222222, '0,            1'b0, 32'h0000000A, 32'h0000000B};
    tv[15] = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b11, 5'd9,  5'd9,  2'b00, 1'b0, 5'd9,  5'd7,  '0,           32'h00000071, 32'h0000_0200, 1'b0, 32'h0000000A, 32'h0000000B};
    tv[16] = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b01, 5'd9,  '0,    2'b00, 1'b0, 5'd9,  5'd7,  '0,           32'h00000071, 32'h0000_0200, 1'b0, 32'h0000000A, 32'h0000000B};
    tv[17] = '{2'b01, 5'd9,  '0,    32'h00000055, '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b10, '0,    5'd9,  2'b01, 1'b1, 5'd9,  5'd7,  32'h00000055, 32'h00000071, '0,            1'b0, 32'h0000000A, 32'h0000000B};
    tv[18] = '{2'b00, '0,    '0,    '0,           '0,           2'b00, 2'b00, '0,          '0,          '0,          '0,          2'b00, '0,    '0,    2'b00, 1'b0, 5'd9,  5'd7,  32'h00000055, 32'h00000071, '0,            1'b0, 32'h0000000A, 32'h0000000B};

    // Reset held low with arbitrary traffic on the inputs.
    resetn = 1'b0;
    hiloreadR = 2'b11;
    reg_addrR[0] = 5'd3; reg_addrR[1] = 5'd5; reg_addrR[2] = 5'd7; reg_addrR[3] = 5'd31;
    ret_wen = 2'b11; ret_waddr[0] = 5'd3; ret_waddr[1] = 5'd5;
    ret_wdata[0] = 32'h1234_5678; ret_wdata[1] = 32'h8765_4321;
    ret_hiwen = 2'b11; ret_lowen = 2'b11;
    ret_hidata[0] = 32'h1; ret_hidata[1] = 32'h2; ret_lodata[0] = 32'h3; ret_lodata[1] = 32'h4;
    iss_wen = 2'b11; iss_waddr[0] = 5'd7; iss_waddr[1] = 5'd31; iss_hilo = 2'b11; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("reset_rd%0d", p), reg_dataR[p], 32'h0);
    chk("reset_hi", hiR, 32'h0);
    chk("reset_lo", loR, 32'h0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_hilo_busy", {31'h0, hilo_busy}, 32'h0);

    @(negedge clk);
    idle();
    resetn = 1'b1;
    reg_addrR[0] = 5'd5;
    @(posedge clk); #1;
    chk("post_reset_r5", reg_dataR[0], 32'h0);

    // Both lanes to r3: invisible before the edge, lane 1 wins after it.
    @(negedge clk);
    iss_wen = 2'b11; iss_waddr[0] = 5'd3; iss_waddr[1] = 5'd3;
    reg_addrR[0] = 5'd3;
    @(posedge clk); #1;
    chk("r3_busy_after_issue", busy, 32'h0000_0008);
    @(negedge clk);
    idle();
    ret_wen = 2'b11; ret_waddr[0] = 5'd3; ret_waddr[1] = 5'd3;
    ret_wdata[0] = 32'h1111_1111; ret_wdata[1] = 32'h2222_2222;
    #1;
    chk("r3_same_cycle_read", reg_dataR[0], 32'h0);
    @(posedge clk); #1;
    chk("r3_lane1_wins", reg_dataR[0], 32'h2222_2222);
    chk("r3_busy_cleared", busy, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tv[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rd0", i), reg_dataR[0], tv[i].e0);
      chk($sformatf("v%0d_rd1", i), reg_dataR[1], tv[i].e1);
      chk($sformatf("v%0d_rd2", i), reg_dataR[2], tv[i].e1);
      chk($sformatf("v%0d_rd3", i), reg_dataR[3], tv[i].e0);
      chk($sformatf("v%0d_busy", i), busy, tv[i].ebusy);
      chk($sformatf("v%0d_hilo_busy", i), {31'h0, hilo_busy}, {31'h0, tv[i].ehb});
      chk($sformatf("v%0d_hi", i), hiR, tv[i].ehi);
      chk($sformatf("v%0d_lo", i), loR, tv[i].elo);
    end

    // Asynchronous reset in the middle of a cycle with writes pending.
    @(negedge clk);
    idle();
    iss_wen = 2'b01; iss_waddr[0] = 5'd5; iss_hilo = 2'b01;
    reg_addrR[0] = 5'd9; reg_addrR[1] = 5'd7; reg_addrR[2] = 5'd5; reg_addrR[3] = 5'd12;
    @(posedge clk); #1;
    chk("mid_busy_before_reset", busy, 32'h0000_0020);
    @(negedge clk);
    idle();
    ret_wen = 2'b01; ret_waddr[0] = 5'd5; ret_wdata[0] = 32'h0000_0099;
    ret_hiwen = 2'b01; ret_hidata[0] = 32'h0000_0077; flush = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_busy", busy, 32'h0);
    chk("async_reset_hilo_busy", {31'h0, hilo_busy}, 32'h0);
    chk("async_reset_r9", reg_dataR[0], 32'h0);
    chk("async_reset_r7", reg_dataR[1], 32'h0);
    chk("async_reset_hi", hiR, 32'h0);
    chk("async_reset_lo", loR, 32'h0);
    @(posedge clk); #1;
    chk("reset_blocks_write_r5", reg_dataR[2], 32'h0);
    chk("reset_blocks_write_hi", hiR, 32'h0);
    @(negedge clk);
    idle();
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("after_release_busy", busy, 32'h0);
    chk("after_release_r12", reg_dataR[3], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
